crc_mac_check: RTL and testbench



---
 rtl/crc_mac_check.sv | 137 +++++++++++++
 tb/tb_crc_mac_check.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/crc_mac_check.sv
// crc_mac_check: checks the Ethernet CRC-32 of 64-bit AXI-Stream frames, strips the FCS
// and forwards the payload, flagging bad or runt frames with tuser on the last beat.
module crc_mac_check #(
    parameter logic [31:0] POLYNOMIAL = 32'hEDB88320,
    parameter logic [31:0] RESIDUE    = 32'hDEBB20E3
) (
    input  logic        clock,
    input  logic        aresetn,
    input  logic [63:0] saxis_tdata,
    input  logic        saxis_tvalid,
    output logic        saxis_tready,
    input  logic [7:0]  saxis_tkeep,
    input  logic        saxis_tlast,
    input  logic        saxis_tuser,
    output logic [63:0] maxis_tdata,
    output logic        maxis_tvalid,
    input  logic        maxis_tready,
    output logic [7:0]  maxis_tkeep,
    output logic        maxis_tlast,
    output logic        maxis_tuser,
    output logic        frame_done,
    output logic        crc_error
);
    typedef enum logic [1:0] {EMPTY, HOLD, FLUSH} state_t;
    state_t state, state_next;
    logic [31:0] crc, crc_next;
    logic [63:0] h_data, o_data;
    logic [7:0] h_keep, o_keep, keep_trim, keep_fold;
    logic h_last, h_user, h_err, o_valid, o_last, o_user, o_err;
    logic [3:0] n;
    logic accept, o_free, h_to_o, short_last, crc_bad;

    function automatic logic [31:0] crc_update(input logic [31:0] c, input logic [63:0] d, input logic [7:0] k);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) begin
                r = r ^ {24'd0, d[8*i +: 8]};
                for (int b = 0; b < 8; b++) r = r[0] ? (r >> 1) ^ POLYNOMIAL : r >> 1;
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] mask(input logic [63:0] d, input logic [7:0] k);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = k[i] ? d[8*i +: 8] : 8'd0;
        return m;
    endfunction

    assign o_free       = !o_valid || maxis_tready;
    assign saxis_tready = aresetn && state != FLUSH && o_free;
    assign accept       = saxis_tvalid && saxis_tready;
    assign n            = 4'($countones(saxis_tkeep));
    assign short_last   = saxis_tlast && n <= 4'd4;
    assign crc_next     = crc_update(crc, saxis_tdata, saxis_tkeep);
    assign crc_bad      = crc_next != RESIDUE;
    // keep_trim: last beat still carries payload; keep_fold: FCS spills back into the held beat
    assign keep_trim    = 8'((9'd1 << (n - 4'd4)) - 9'd1);
    assign keep_fold    = 8'hFF >> (4'd4 - n);
    assign h_to_o       = (state == HOLD && accept && !short_last) || (state == FLUSH && o_free);

    assign maxis_tdata  = o_data;
    assign maxis_tvalid = o_valid;
    assign maxis_tkeep  = o_keep;
    assign maxis_tlast  = o_last;
    assign maxis_tuser  = o_user;
    assign frame_done   = o_valid && maxis_tready && o_last;
    assign crc_error    = frame_done && o_err;

    always_comb begin
        state_next = state;
        if (state == FLUSH) state_next = o_free ? EMPTY : FLUSH;
        else if (accept) state_next = saxis_tlast ? FLUSH : HOLD;
    end

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) state <= EMPTY;
        else state <= state_next;
    end

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            crc     <= 32'hFFFFFFFF;
            h_data  <= '0;
            h_keep  <= '0;
            h_last  <= 1'b0;
            h_user  <= 1'b0;
            h_err   <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_keep  <= '0;
            o_last  <= 1'b0;
            o_user  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            if (accept) crc <= saxis_tlast ? 32'hFFFFFFFF : crc_next;
            if (h_to_o) begin
                o_valid <= 1'b1;
                o_data  <= h_data;
                o_keep  <= h_keep;
                o_last  <= h_last;
                o_user  <= h_user;
                o_err   <= h_err;
            end else if (maxis_tready) begin
                o_valid <= 1'b0;
            end
            if (accept) begin
                if (!saxis_tlast) begin
                    h_data <= saxis_tdata;
                    h_keep <= saxis_tkeep;
                    h_last <= 1'b0;
                    h_user <= 1'b0;
                    h_err  <= 1'b0;
                end else if (!short_last) begin
                    h_data <= mask(saxis_tdata, keep_trim);
                    h_keep <= keep_trim;
                    h_last <= 1'b1;
                    h_user <= saxis_tuser || crc_bad;
                    h_err  <= crc_bad;
                end else if (state == HOLD) begin
                    h_data <= mask(h_data, keep_fold);
                    h_keep <= keep_fold;
                    h_last <= 1'b1;
                    h_user <= saxis_tuser || crc_bad;
                    h_err  <= crc_bad;
                end else begin
                    h_data <= '0;
                    h_keep <= '0;
                    h_last <= 1'b1;
                    h_user <= 1'b1;
                    h_err  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_crc_mac_check.sv
// tb_crc_mac_check: randomized and directed frames checked against a byte-level FCS model.
module tb_crc_mac_check;
    typedef logic [7:0] bytes_t[$];
    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l, u, e;
    } beat_t;

    logic clock = 1'b0;
    logic aresetn = 1'b0;
    logic [63:0] saxis_tdata, maxis_tdata;
    logic saxis_tvalid, saxis_tready, saxis_tlast, saxis_tuser;
    logic [7:0] saxis_tkeep, maxis_tkeep;
    logic maxis_tvalid, maxis_tready, maxis_tlast, maxis_tuser, frame_done, crc_error;
    int checks = 0;
    int errors = 0;
    bit rnd_rdy = 1'b0;
    beat_t exp_q[$];

    crc_mac_check dut (
        .clock(clock), .aresetn(aresetn),
        .saxis_tdata(saxis_tdata), .saxis_tvalid(saxis_tvalid), .saxis_tready(saxis_tready),
        .saxis_tkeep(saxis_tkeep), .saxis_tlast(saxis_tlast), .saxis_tuser(saxis_tuser),
        .maxis_tdata(maxis_tdata), .maxis_tvalid(maxis_tvalid), .maxis_tready(maxis_tready),
        .maxis_tkeep(maxis_tkeep), .maxis_tlast(maxis_tlast), .maxis_tuser(maxis_tuser),
        .frame_done(frame_done), .crc_error(crc_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc32(input bytes_t b);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'd0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bytes_t with_fcs(input bytes_t f);
        bytes_t r;
        logic [31:0] c;
        r = f;
        c = crc32(f);
        for (int k = 0; k < 4; k++) r.push_back(c[8*k +: 8]);
        return r;
    endfunction

    task automatic expect_frame(input bytes_t f, input logic ut);
        bytes_t p;
        beat_t bt;
        logic [31:0] fcs;
        logic good;
        int len;
        len = f.size();
        if (len <= 4) begin
            bt = '{64'd0, 8'd0, 1'b1, 1'b1, 1'b1};
            exp_q.push_back(bt);
            return;
        end
        p = {};
        for (int i = 0; i < len - 4; i++) p.push_back(f[i]);
        fcs = {f[len-1], f[len-2], f[len-3], f[len-4]};
        good = crc32(p) == fcs;
        for (int i = 0; i < p.size(); i += 8) begin
            bt.d = '0;
            bt.k = '0;
            for (int j = 0; j < 8; j++) begin
                if (i + j < p.size()) begin
                    bt.d[8*j +: 8] = p[i+j];
                    bt.k[j] = 1'b1;
                end
            end
            bt.l = i + 8 >= p.size();
            bt.u = bt.l && (ut || !good);
            bt.e = bt.l && !good;
            exp_q.push_back(bt);
        end
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        int t;
        bit done;
        saxis_tdata = d;
        saxis_tkeep = k;
        saxis_tlast = l;
        saxis_tuser = u;
        saxis_tvalid = 1'b1;
        t = 0;
        done = 1'b0;
        while (!done && t < 2000) begin
            @(negedge clock);
            done = saxis_tready;
            @(posedge clock);
            #1;
            t++;
        end
        saxis_tvalid = 1'b0;
        saxis_tlast = 1'b0;
        saxis_tuser = 1'b0;
        if (!done) check("accept_timeout", 64'(done), 64'd1);
    endtask

    task automatic send_frame(input bytes_t f, input logic ut, input int max_gap);
        logic [63:0] d;
        logic [7:0] k;
        expect_frame(f, ut);
        for (int i = 0; i < f.size(); i += 8) begin
            d = '0;
            k = '0;
            for (int j = 0; j < 8; j++) begin
                if (i + j < f.size()) begin
                    d[8*j +: 8] = f[i+j];
                    k[j] = 1'b1;
                end
            end
            repeat ($urandom_range(max_gap, 0)) begin
                @(posedge clock);
                #1;
            end
            send_beat(d, k, i + 8 >= f.size(), ut);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(posedge clock);
            t++;
        end
        repeat (3) @(posedge clock);
        #1;
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tvalid"}, 64'(maxis_tvalid), 64'd0);
        check({tag, "_tdata"}, maxis_tdata, 64'd0);
        check({tag, "_tkeep"}, 64'(maxis_tkeep), 64'd0);
        check({tag, "_tlast"}, 64'(maxis_tlast), 64'd0);
        check({tag, "_tuser"}, 64'(maxis_tuser), 64'd0);
        check({tag, "_sready"}, 64'(saxis_tready), 64'd0);
        check({tag, "_done"}, 64'(frame_done), 64'd0);
        check({tag, "_crcerr"}, 64'(crc_error), 64'd0);
    endtask

    function automatic bytes_t rand_bytes(input int len);
        bytes_t r;
        r = {};
        for (int i = 0; i < len; i++) r.push_back(8'($urandom_range(255, 0)));
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clock);
            #1;
            maxis_tready = rnd_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
        end
    end

    initial begin
        beat_t e;
        forever begin
            @(negedge clock);
            if (aresetn && maxis_tvalid && maxis_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("tdata", maxis_tdata, e.d);
                    check("tkeep", 64'(maxis_tkeep), 64'(e.k));
                    check("tlast", 64'(maxis_tlast), 64'(e.l));
                    check("tuser", 64'(maxis_tuser), 64'(e.u));
                    check("frame_done", 64'(frame_done), 64'(e.l));
                    check("crc_error", 64'(crc_error), 64'(e.e));
                end
            end
        end
    end

    initial begin
        bytes_t f1, f;
        saxis_tdata = '0;
        saxis_tkeep = '0;
        saxis_tvalid = 1'b0;
        saxis_tlast = 1'b0;
        saxis_tuser = 1'b0;
        maxis_tready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_idle("reset");
        aresetn = 1'b1;
        #1;
        check("ready_after_reset", 64'(saxis_tready), 64'd1);
        @(posedge clock);
        #1;
        f1 = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        f1 = with_fcs(f1);
        send_frame(f1, 1'b0, 0);
        f = f1;
        f[4] = f[4] ^ 8'h01;
        send_frame(f, 1'b0, 0);
        send_frame(with_fcs(rand_bytes(8)), 1'b0, 0);
        send_frame(with_fcs(rand_bytes(13)), 1'b0, 0);
        send_frame(rand_bytes(3), 1'b0, 0);
        send_frame(rand_bytes(4), 1'b0, 0);
        send_frame(with_fcs(rand_bytes(10)), 1'b1, 0);
        send_frame(with_fcs(rand_bytes(1)), 1'b0, 0);
        wait_drain();
        rnd_rdy = 1'b1;
        for (int i = 0; i < 100; i++) send_frame(with_fcs(rand_bytes($urandom_range(24, 1))), 1'b0, 3);
        wait_drain();
        send_beat(64'h0706050403020100, 8'hFF, 1'b0, 1'b0);
        aresetn = 1'b0;
        #2;
        check_idle("midreset");
        @(posedge clock);
        #1;
        aresetn = 1'b1;
        @(posedge clock);
        #1;
        send_frame(with_fcs(rand_bytes(11)), 1'b0, 1);
        wait_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
